interrupt_controller: RTL and testbench

- Collects the external peripheral interrupt lines and synchronises, latches, masks and priority-arbitrates them.
- Drives the single interrupt request consumed by the coprocessor-0 exception logic as its external-interrupt input.
- Tracks the in-service source from acknowledge until the handler's eret, and blocks further requests while one is in service.
- Software configures and inspects it through a small memory-mapped register port on the CPU data bus.

---
 rtl/intc_pkg.sv | 12 +
 rtl/intc_priority_enc.sv | 17 +
 rtl/interrupt_controller.sv | 122 ++++++++++++
 tb/tb_interrupt_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared register map, bit positions and FSM encoding for the interrupt controller.
package intc_pkg;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int CTRL_GIE_BIT   = 0;
  localparam int STAT_INSVC_BIT = 31;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
endpackage

// File: rtl/intc_priority_enc.sv
// Lowest-index-first priority encoder: bit 0 wins over every higher bit.
module intc_priority_enc #(
  parameter int NUM_IRQ = 6,
  parameter int ID_W    = 3
) (
  input  logic [NUM_IRQ-1:0] vec_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);
  always_comb begin
    valid_o = |vec_i;
    id_o    = '0;
    // Scan downward so the last hit, the lowest index, sticks.
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (vec_i[i]) id_o = ID_W'(i);
  end
endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: sync, pending latch, mask/GIE, priority arbitration, REQ/SERVICE tracking.
// Build option INTC_EDGE_TRIGGER_EN: edge-set / W1C / ack-clear pending instead of level pending.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 6,
  parameter int ID_W    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               reg_cs,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  input  logic               eret
);
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, pend_q, pend_d, mask_q, eligible;
  logic               gie_q, wr_en, win_vld;
  logic [ID_W-1:0]    win_id, int_id_q;
  logic               int_req_q;
  state_e             state_q;
  logic               unused_wdata;

  assign wr_en        = reg_cs & reg_we;
  assign unused_wdata = ^reg_wdata[31:NUM_IRQ];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      gie_q   <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      pend_q  <= pend_d;
      if (wr_en && reg_addr == ADDR_CTRL) gie_q  <= reg_wdata[CTRL_GIE_BIT];
      if (wr_en && reg_addr == ADDR_MASK) mask_q <= reg_wdata[NUM_IRQ-1:0];
    end
  end

`ifdef INTC_EDGE_TRIGGER_EN
  logic [NUM_IRQ-1:0] sync3_q, rise, clr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync3_q <= '0;
    else        sync3_q <= sync2_q;
  end

  assign rise = sync2_q & ~sync3_q;

  // Clear sources are applied first so a same-cycle rising edge still sets the bit.
  always_comb begin
    clr = '0;
    if (wr_en && reg_addr == ADDR_PEND) clr = reg_wdata[NUM_IRQ-1:0];
    if (state_q == REQ && int_ack) clr[int_id_q] = 1'b1;
    pend_d = (pend_q & ~clr) | rise;
  end
`else
  assign pend_d = sync2_q;
`endif

  assign eligible = gie_q ? (pend_q & mask_q) : '0;

  intc_priority_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_enc (
    .vec_i   (eligible),
    .valid_o (win_vld),
    .id_o    (win_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_vld) begin
          state_q   <= REQ;
          int_req_q <= 1'b1;
          int_id_q  <= win_id;
        end
        REQ: if (int_ack) begin
          state_q   <= SERVICE;
          int_req_q <= 1'b0;
        end else if (!win_vld) begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end else begin
          int_id_q  <= win_id;
        end
        SERVICE: if (eret) state_q <= IDLE;
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_CTRL: reg_rdata[CTRL_GIE_BIT] = gie_q;
      ADDR_MASK: reg_rdata[NUM_IRQ-1:0]  = mask_q;
      ADDR_PEND: reg_rdata[NUM_IRQ-1:0]  = pend_q;
      default: begin
        reg_rdata[STAT_INSVC_BIT] = (state_q == SERVICE);
        reg_rdata[ID_W-1:0]       = int_id_q;
      end
    endcase
  end
endmodule

// File: tb/tb_interrupt_controller.sv
// Scenario bench for interrupt_controller: expected values queued at stimulus time, popped at check time.
module tb_interrupt_controller;
  localparam int NUM_IRQ = 6;
  localparam int ID_W    = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic               reg_cs = 1'b0, reg_we = 1'b0;
  logic [1:0]         reg_addr = 2'd0;
  logic [31:0]        reg_wdata = '0;
  logic [31:0]        reg_rdata;
  logic               int_req;
  logic [ID_W-1:0]    int_id;
  logic               int_ack = 1'b0, eret = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs, ev;

  interrupt_controller #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .reg_cs(reg_cs), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .int_req(int_req), .int_id(int_id), .int_ack(int_ack), .eret(eret)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_cs = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_cs = 1'b0; reg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    reg_addr = a;
    #1 v = reg_rdata;
  endtask

  task automatic test_reset();
    tick(2);
    reset = 1'b1;
    tick();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL rst_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL rst_id got %h want %h", obs, ev); miscompares++; end
    rd(2'd0, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL rst_ctrl got %h want %h", obs, ev); miscompares++; end
    rd(2'd1, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL rst_mask got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL rst_stat got %h want %h", obs, ev); miscompares++; end
  endtask

  task automatic test_latency();
    wr(2'd1, 32'h04);
    wr(2'd0, 32'h1);
    irq_in[2] = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h0);
    tick(3);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL lat_edge3_req got %h want %h", obs, ev); miscompares++; end
    tick();
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL lat_edge4_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL lat_id got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); obs = {31'b0, obs[31]}; ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL lat_insvc got %h want %h", obs, ev); miscompares++; end
    irq_in[2] = 1'b0;
    tick(5);
  endtask

  task automatic test_priority();
    wr(2'd1, 32'h3F);
    irq_in[5] = 1'b1; irq_in[1] = 1'b1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    exp_q.push_back(32'h80000001); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    exp_q.push_back(32'h5); exp_q.push_back(32'h0);
    tick(4);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL pri_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL pri_id got %h want %h", obs, ev); miscompares++; end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL ack_req got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL ack_stat got %h want %h", obs, ev); miscompares++; end
    irq_in[1] = 1'b0;
    tick(4);
    eret = 1'b1; tick(); eret = 1'b0;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL eret_req got %h want %h", obs, ev); miscompares++; end
    tick();
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL rearm_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL rearm_id got %h want %h", obs, ev); miscompares++; end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    irq_in[5] = 1'b0;
    tick(4);
    eret = 1'b1; tick(); eret = 1'b0;
    tick(2);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL drain_req got %h want %h", obs, ev); miscompares++; end
  endtask

  task automatic test_mask_drop();
    irq_in[3] = 1'b1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h3); exp_q.push_back(32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h08);
    tick(4);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL md_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL md_id got %h want %h", obs, ev); miscompares++; end
    wr(2'd1, 32'h37);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL md_wredge_req got %h want %h", obs, ev); miscompares++; end
    tick();
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL md_fall_req got %h want %h", obs, ev); miscompares++; end
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL md_pend got %h want %h", obs, ev); miscompares++; end
  endtask

  task automatic test_stray_pulses();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    exp_q.push_back(32'h3); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL idle_ack_req got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); obs = {31'b0, obs[31]}; ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL idle_ack_insvc got %h want %h", obs, ev); miscompares++; end
    wr(2'd1, 32'h3F);
    tick();
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL remask_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL remask_id got %h want %h", obs, ev); miscompares++; end
    eret = 1'b1; tick(); eret = 1'b0;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL req_eret_req got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); obs = {31'b0, obs[31]}; ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL req_eret_insvc got %h want %h", obs, ev); miscompares++; end
    int_ack = 1'b1; eret = 1'b1; tick(); int_ack = 1'b0; eret = 1'b0;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL both_req got %h want %h", obs, ev); miscompares++; end
    rd(2'd3, obs); obs = {31'b0, obs[31]}; ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL both_insvc got %h want %h", obs, ev); miscompares++; end
    irq_in[3] = 1'b0;
    tick(4);
    eret = 1'b1; tick(); eret = 1'b0;
    tick(2);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL stray_drain_req got %h want %h", obs, ev); miscompares++; end
  endtask

  task automatic test_pending_mode();
    wr(2'd1, 32'h0);
    irq_in[0] = 1'b1;
`ifdef INTC_EDGE_TRIGGER_EN
    exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    tick(3);
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL edge_set got %h want %h", obs, ev); miscompares++; end
    wr(2'd2, 32'h1);
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL w1c got %h want %h", obs, ev); miscompares++; end
    irq_in[0] = 1'b0;
    tick(3);
    irq_in[0] = 1'b1;
    tick(2);
    wr(2'd2, 32'h1);
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL set_beats_clr got %h want %h", obs, ev); miscompares++; end
`else
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    tick(3);
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL level_pend got %h want %h", obs, ev); miscompares++; end
    wr(2'd2, 32'h1);
    rd(2'd2, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL level_wr_ignored got %h want %h", obs, ev); miscompares++; end
`endif
    irq_in[0] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_in_service();
    wr(2'd1, 32'h3F);
    irq_in[4] = 1'b1;
    tick(4);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    exp_q.push_back(32'h80000004); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(2'd3, obs); ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL svc_stat got %h want %h", obs, ev); miscompares++; end
    reset = 1'b0;
    #1;
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL arst_req got %h want %h", obs, ev); miscompares++; end
    ev = exp_q.pop_front(); obs = {29'b0, int_id}; vectors++;
    if (obs !== ev) begin $display("FAIL arst_id got %h want %h", obs, ev); miscompares++; end
    reg_addr = 2'd1; #0.1; obs = reg_rdata; ev = exp_q.pop_front(); vectors++;
    if (obs !== ev) begin $display("FAIL arst_mask got %h want %h", obs, ev); miscompares++; end
    reset = 1'b1;
    tick(6);
    ev = exp_q.pop_front(); obs = {31'b0, int_req}; vectors++;
    if (obs !== ev) begin $display("FAIL post_rst_req got %h want %h", obs, ev); miscompares++; end
    irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_mask_drop();
    test_stray_pulses();
    test_pending_mode();
    test_reset_in_service();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
